sample_display_driver: RTL and testbench

//   Consumer end of the filter sample path: accepts signed samples (e.g. moving-average Z)

---
 rtl/sample_display_driver_if.sv | 24 ++
 rtl/sample_display_driver.sv | 148 ++++++++++++++
 tb/tb_sample_display_driver.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sample_display_driver_if.sv
// Sample handshake between a signed-sample source and the display driver.
// Source drives enable/valid/data; the driver answers with ready.
interface sample_display_driver_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             sample_valid;
  logic [WIDTH-1:0] sample_in;
  logic             sample_ready;

  modport master (
    output enable,
    output sample_valid,
    output sample_in,
    input  sample_ready
  );

  modport slave (
    input  enable,
    input  sample_valid,
    input  sample_in,
    output sample_ready
  );
endinterface

// File: rtl/sample_display_driver.sv
// Signed sample to four active-low 7-segment displays.
// Sign on HEX3, decimal magnitude on HEX2..HEX0 via serial double dabble.
module sample_display_driver #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 0
) (
  input  logic                    Clk,
  input  logic                    Reset,
  sample_display_driver_if.slave  s,
  output logic                    busy,
  output logic [6:0]              HEX0,
  output logic [6:0]              HEX1,
  output logic [6:0]              HEX2,
  output logic [6:0]              HEX3
);
  localparam int CW = $clog2(WIDTH);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    LATCH,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [6:0]       hex0_q, hex0_d;
  logic [6:0]       hex1_q, hex1_d;
  logic [6:0]       hex2_q, hex2_d;
  logic [6:0]       hex3_q, hex3_d;
  logic             accept;

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      default: r = SEG_BLANK;
    endcase
    return r;
  endfunction

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign s.sample_ready = s.enable & (state_q == IDLE);
  assign accept         = s.sample_valid & s.sample_ready;
  assign busy           = (state_q != IDLE);
  assign HEX0           = hex0_q;
  assign HEX1           = hex1_q;
  assign HEX2           = hex2_q;
  assign HEX3           = hex3_q;

  // Next-state: capture, shift-add-3 per bit, latch digits, then hold.
  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    hex0_d  = hex0_q;
    hex1_d  = hex1_q;
    hex2_d  = hex2_q;
    hex3_d  = hex3_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          neg_d   = s.sample_in[WIDTH-1];
          mag_d   = s.sample_in[WIDTH-1] ?
                    (~s.sample_in + WIDTH'(1)) : s.sample_in;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        {bcd_d, mag_d} = {add3(bcd_q), mag_q} << 1;
        cnt_d = cnt_q + CW'(1);
        if (int'(cnt_q) == WIDTH - 1) state_d = LATCH;
      end
      LATCH: begin
        hex0_d = seg(bcd_q[3:0]);
        hex1_d = (bcd_q[11:4] == 8'd0) ? SEG_BLANK : seg(bcd_q[7:4]);
        hex2_d = (bcd_q[11:8] == 4'd0) ? SEG_BLANK : seg(bcd_q[11:8]);
        hex3_d = neg_q ? SEG_MINUS : SEG_BLANK;
        hold_d = '0;
        if (HOLD_CYCLES == 0) state_d = IDLE;
        else                  state_d = HOLD;
      end
      HOLD: begin
        if (int'(hold_q) == HOLD_CYCLES - 1) state_d = IDLE;
        else                                 hold_d  = hold_q + HW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and display registers; reset aborts any conversion at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      hex0_q  <= SEG_ZERO;
      hex1_q  <= SEG_BLANK;
      hex2_q  <= SEG_BLANK;
      hex3_q  <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      hex0_q  <= hex0_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
      hex3_q  <= hex3_d;
    end
  end
endmodule

// File: tb/tb_sample_display_driver.sv
// Bench for sample_display_driver: two instances (no hold, hold of 4)
// against a timeline model that computes digits with plain arithmetic.
module tb_sample_display_driver;
  localparam int W = 8;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b0111111;

  logic clk = 1'b0;
  logic Reset = 1'b0;
  always #5 clk = ~clk;

  logic             en  [2];
  logic             vld [2];
  logic [W-1:0]     smp [2];
  logic             rdy [2];
  logic             bsy [2];
  logic [3:0][6:0]  hx  [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_on = 0;

  sample_display_driver_if #(.WIDTH(W)) if0 ();
  sample_display_driver_if #(.WIDTH(W)) if1 ();

  assign if0.enable       = en[0];
  assign if0.sample_valid = vld[0];
  assign if0.sample_in    = smp[0];
  assign rdy[0]           = if0.sample_ready;
  assign if1.enable       = en[1];
  assign if1.sample_valid = vld[1];
  assign if1.sample_in    = smp[1];
  assign rdy[1]           = if1.sample_ready;

  sample_display_driver #(.WIDTH(W), .HOLD_CYCLES(0)) dut0 (
    .Clk(clk), .Reset(Reset), .s(if0), .busy(bsy[0]),
    .HEX0(hx[0][0]), .HEX1(hx[0][1]), .HEX2(hx[0][2]), .HEX3(hx[0][3])
  );
  sample_display_driver #(.WIDTH(W), .HOLD_CYCLES(4)) dut1 (
    .Clk(clk), .Reset(Reset), .s(if1), .busy(bsy[1]),
    .HEX0(hx[1][0]), .HEX1(hx[1][1]), .HEX2(hx[1][2]), .HEX3(hx[1][3])
  );

  function automatic logic [6:0] seg(input int d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[d];
  endfunction

  // Model: edges remaining until idle / until the new digits appear.
  int              busy_left [2];
  int              lat_left  [2];
  logic [3:0][6:0] ex        [2];
  logic [3:0][6:0] pend      [2];
  int              hold_len  [2];

  initial begin
    hold_len[0] = 0;
    hold_len[1] = 4;
    for (int i = 0; i < 2; i++) begin
      busy_left[i] = 0;
      lat_left[i]  = 0;
      ex[i]   = {BL, BL, BL, seg(0)};
      pend[i] = {BL, BL, BL, seg(0)};
    end
  end

  always @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 2; i++) begin
        busy_left[i] = 0;
        lat_left[i]  = 0;
        ex[i] = {BL, BL, BL, seg(0)};
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (busy_left[i] > 0) begin
          busy_left[i]--;
          if (lat_left[i] > 0) begin
            lat_left[i]--;
            if (lat_left[i] == 0) ex[i] = pend[i];
          end
        end else if (en[i] && vld[i]) begin
          int v, m, h, t, o;
          v = int'($signed(smp[i]));
          m = (v < 0) ? -v : v;
          h = m / 100;
          t = (m / 10) % 10;
          o = m % 10;
          pend[i][0] = seg(o);
          pend[i][1] = (h == 0 && t == 0) ? BL : seg(t);
          pend[i][2] = (h == 0) ? BL : seg(h);
          pend[i][3] = (v < 0) ? MI : BL;
          lat_left[i]  = W + 1;
          busy_left[i] = W + 1 + hold_len[i];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("hex%0d", i), 32'(hx[i]), 32'(ex[i]));
        chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(busy_left[i] > 0));
        chk($sformatf("ready%0d", i), 32'(rdy[i]),
            32'(en[i] && busy_left[i] == 0));
      end
    end
  end

  task automatic send(input int i, input int val, output int acc);
    acc = -1;
    vld[i] = 1'b1;
    smp[i] = W'(val);
    for (int k = 0; k < 100; k++) begin
      if (rdy[i]) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    vld[i] = 1'b0;
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL send_timeout: got no accept expected accept of %0d", val);
    end
  endtask

  task automatic wait_idle(input int i);
    bit ok;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      if (rdy[i]) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout: got busy expected ready on dut%0d", i);
    end
  endtask

  int a0, a1;

  initial begin
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b1; vld[i] = 1'b0; smp[i] = '0;
    end
    #1 Reset = 1'b1;
    #1 chk_on = 1;
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    #1;
    chk("rst_hex", 32'(hx[0]), 32'({BL, BL, BL, 7'b1000000}));
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    chk("rst_busy", 32'(bsy[0]), 32'd0);

    send(0, 5, a0);
    repeat (8) @(posedge clk);
    #1;
    chk("five_busy_e8", 32'(bsy[0]), 32'd1);
    @(posedge clk); #1;
    chk("five_hex", 32'(hx[0]), 32'({BL, BL, BL, 7'b0010010}));
    chk("five_ready_e9", 32'(rdy[0]), 32'd1);

    send(0, -128, a0);
    wait_idle(0);
    chk("m128_hex", 32'(hx[0]),
        32'({7'b0111111, 7'b1111001, 7'b0100100, 7'b0000000}));

    send(0, 100, a0);
    wait_idle(0);
    chk("h100_hex", 32'(hx[0]),
        32'({BL, 7'b1111001, 7'b1000000, 7'b1000000}));
    send(0, 7, a0);
    wait_idle(0);
    chk("seven_hex", 32'(hx[0]), 32'({BL, BL, BL, 7'b1111000}));

    send(0, 42, a0);
    repeat (2) @(posedge clk);
    #1 en[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("en_drop_hex", 32'(hx[0]),
        32'({BL, BL, 7'b0011001, 7'b0100100}));
    vld[0] = 1'b1; smp[0] = W'(3);
    repeat (3) @(posedge clk);
    #1 vld[0] = 1'b0;
    chk("en_low_ignored", 32'(hx[0]),
        32'({BL, BL, 7'b0011001, 7'b0100100}));
    en[0] = 1'b1;

    send(1, 3, a0);
    send(1, 9, a1);
    chk("hold_gap", 32'(a1 - a0), 32'd14);
    wait_idle(1);
    chk("hold_nine", 32'(hx[1]), 32'({BL, BL, BL, 7'b0010000}));

    send(0, -77, a0);
    repeat (4) @(posedge clk);
    #1 Reset = 1'b1;
    #1;
    chk("abort_hex", 32'(hx[0]), 32'({BL, BL, BL, 7'b1000000}));
    chk("abort_busy", 32'(bsy[0]), 32'd0);
    @(posedge clk); #1 Reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("no_m77", 32'(hx[0]), 32'({BL, BL, BL, 7'b1000000}));
    send(0, 0, a0);
    wait_idle(0);
    chk("zero_hex", 32'(hx[0]), 32'({BL, BL, BL, 7'b1000000}));

    repeat (3) @(posedge clk);
    #1 chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
